// File: rtl/ring_pkg.sv
// Shared types and helpers for one-hot ring counter consumers.
// Helpers work on a zero-extended word so any ring width up to RING_MAX_N can reuse them.
package ring_pkg;

  localparam int RING_MAX_N = 64;
  localparam int RING_IDX_W = 6;

  typedef logic [RING_MAX_N-1:0] ring_word_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } ring_state_t;

  typedef struct packed {
    logic                  legal;
    logic [RING_IDX_W-1:0] idx;
  } ring_onehot_t;

  // Rotate the low n bits of value by one place; bits at and above n come back as 0.
  function automatic ring_word_t ring_rotate(input ring_word_t value, input int n,
                                             input logic dir_right);
    ring_word_t rot;
    rot = '0;
    for (int i = 0; i < RING_MAX_N; i++) begin
      if (i >= n) begin
        rot[i] = 1'b0;
      end else if (dir_right) begin
        rot[i] = (i == n - 1) ? value[0] : value[(i + 1) % RING_MAX_N];
      end else begin
        rot[i] = (i == 0) ? value[n - 1] : value[(i + RING_MAX_N - 1) % RING_MAX_N];
      end
    end
    return rot;
  endfunction

  function automatic ring_onehot_t onehot_index(input ring_word_t value, input int n);
    ring_onehot_t res;
    int           ones;
    res  = '0;
    ones = 0;
    for (int i = 0; i < RING_MAX_N; i++) begin
      if (i < n && value[i]) begin
        ones++;
        res.idx = RING_IDX_W'(i);
      end else begin
        ones = ones;
      end
    end
    res.legal = (ones == 1);
    if (!res.legal) begin
      res.idx = '0;
    end else begin
      res.idx = res.idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot legality check and hot-bit index decode for an N-bit ring.
module ring_onehot_decode
  import ring_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  value,
  output logic [IW-1:0] idx,
  output logic          legal
);

  ring_onehot_t dec_s;
  logic         unused_idx_bits_s;

  // Decode through the shared helper; idx is 0 whenever the value is not one-hot.
  always_comb begin
    dec_s = onehot_index(ring_word_t'(value), N);
    idx   = dec_s.idx[IW-1:0];
    legal = dec_s.legal;
  end

  assign unused_idx_bits_s = ^dec_s.idx;

endmodule

// File: rtl/ring_monitor.sv
// Receive-side checker for one-hot rotating ring counters: acquires lock on
// consecutive correct rotations, then counts errors and completed revolutions.
module ring_monitor
  import ring_pkg::*;
#(
  parameter int N         = 3,
  parameter bit DIR_RIGHT = 1'b1,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_W     = 8,
  parameter int REV_W     = 8,
  localparam int IW       = (N > 2) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     ring_in,
  input  logic             ring_vld,
  output logic [IW-1:0]    idx,
  output logic             onehot_ok,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             rev_pulse,
  output logic [REV_W-1:0] rev_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  ring_state_t   state_r;
  logic [N-1:0]  prev_r;
  logic [GW-1:0] good_cnt_r;

  logic [IW-1:0] dec_idx_s;
  logic          legal_s;
  logic          match_s;
  logic [N-1:0]  expected_s;
  ring_word_t    rot_word_s;
  logic          unused_rot_bits_s;

  ring_onehot_decode #(.N(N), .IW(IW)) u_decode (
    .value (ring_in),
    .idx   (dec_idx_s),
    .legal (legal_s)
  );

  // Next value the ring must show if it advanced exactly one step from prev.
  always_comb begin
    rot_word_s = ring_rotate(ring_word_t'(prev_r), N, DIR_RIGHT);
    expected_s = rot_word_s[N-1:0];
    match_s    = (ring_in == expected_s);
  end

  assign unused_rot_bits_s = ^rot_word_s;

  // Lock FSM, sample outputs and counters; pulses clear on any cycle without a check.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= UNLOCKED;
      prev_r     <= '0;
      good_cnt_r <= '0;
      idx        <= '0;
      onehot_ok  <= 1'b0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      rev_pulse  <= 1'b0;
      rev_cnt    <= '0;
    end else begin
      err_pulse <= 1'b0;
      rev_pulse <= 1'b0;
      if (ring_vld) begin
        idx       <= dec_idx_s;
        onehot_ok <= legal_s;
        case (state_r)
          UNLOCKED: begin
            if (legal_s) begin
              prev_r     <= ring_in;
              good_cnt_r <= '0;
              state_r    <= ACQUIRE;
            end else begin
              state_r <= UNLOCKED;
            end
          end
          ACQUIRE: begin
            if (match_s) begin
              prev_r     <= ring_in;
              good_cnt_r <= good_cnt_r + GW'(1);
              if (good_cnt_r == GW'(LOCK_CNT - 1)) begin
                state_r <= LOCKED;
                locked  <= 1'b1;
              end else begin
                state_r <= ACQUIRE;
              end
            end else if (legal_s) begin
              prev_r     <= ring_in;
              good_cnt_r <= '0;
            end else begin
              state_r <= UNLOCKED;
            end
          end
          LOCKED: begin
            if (match_s) begin
              prev_r <= ring_in;
              if (ring_in[0]) begin
                rev_pulse <= 1'b1;
                rev_cnt   <= rev_cnt + REV_W'(1);
              end else begin
                rev_pulse <= 1'b0;
              end
            end else begin
              err_pulse  <= 1'b1;
              locked     <= 1'b0;
              good_cnt_r <= '0;
              if (err_cnt != {ERR_W{1'b1}}) begin
                err_cnt <= err_cnt + ERR_W'(1);
              end else begin
                err_cnt <= err_cnt;
              end
              if (legal_s) begin
                prev_r  <= ring_in;
                state_r <= ACQUIRE;
              end else begin
                state_r <= UNLOCKED;
              end
            end
          end
          default: begin
            state_r <= UNLOCKED;
            locked  <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule
